// File: rtl/gw2a_ddr_rdalign.sv
// GW2A DDR read-capture aligner: per-lane IDES4 bit-pair pick with optional half-word slip,
// plus a calibration FSM that sweeps every select against a training pattern.
module gw2a_ddr_rdalign #(
  parameter int         LANES   = 8,
  parameter logic [3:0] PATTERN = 4'b1001,
  parameter int         SETTLE  = 4,
  parameter int         CHECKS  = 8
) (
  input  logic               PCLK,
  input  logic               RESET_N,
  input  logic               CALIB_REQ,
  input  logic               SHIFT_WE,
  input  logic [3*LANES-1:0] SHIFT_I,
  input  logic [4*LANES-1:0] DI,
  output logic [LANES-1:0]   Q0,
  output logic [LANES-1:0]   Q1,
  output logic [3*LANES-1:0] SHIFT_O,
  output logic [LANES-1:0]   LOCKED,
  output logic               PHASE,
  output logic               BUSY,
  output logic               DONE,
  output logic               FAIL
);
  localparam int CNT_MAX = (SETTLE > CHECKS) ? SETTLE : CHECKS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_ADVANCE, S_FINISH} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         trial, trial_nx;
  logic [LANES-1:0]   pass, pass_nx, locked_nx, lock_acc;
  logic [3*LANES-1:0] shift_nx;
  logic               busy_nx, done_nx, fail_nx;
  logic [LANES-1:0]   a_p0, b_p0, b_p1, slip_p0, match;
  logic               settle_end, check_end, adv_finish;

  // Stage 0: bit-pair pick from the current nibble, match test on the registered outputs
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2:0] sel;
    logic [3:0] nib;
    logic [1:0] idx_b;
    assign sel        = SHIFT_O[3*l +: 3];
    assign nib        = DI[4*l +: 4];
    assign idx_b      = sel[1:0] + 2'd2;
    assign a_p0[l]    = nib[sel[1:0]];
    assign b_p0[l]    = nib[idx_b];
    assign slip_p0[l] = sel[2];
    assign match[l]   = PHASE ? ({Q1[l], Q0[l]} == PATTERN[3:2])
                              : ({Q1[l], Q0[l]} == PATTERN[1:0]);
  end

  assign settle_end = (state == S_SETTLE) && (cnt == CNT_W'(SETTLE - 1));
  assign check_end  = (state == S_CHECK)  && (cnt == CNT_W'(CHECKS - 1));
  assign lock_acc   = LOCKED | pass;
  assign adv_finish = (&lock_acc) || (trial == 3'd7);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (CALIB_REQ) state_nx = S_SETTLE;
      S_SETTLE:  if (settle_end) state_nx = S_CHECK;
      S_CHECK:   if (check_end) state_nx = S_ADVANCE;
      S_ADVANCE: state_nx = adv_finish ? S_FINISH : S_SETTLE;
      S_FINISH:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    shift_nx  = SHIFT_O;
    locked_nx = LOCKED;
    pass_nx   = pass;
    cnt_nx    = cnt;
    trial_nx  = trial;
    busy_nx   = BUSY;
    done_nx   = DONE;
    fail_nx   = FAIL;
    case (state)
      S_IDLE: begin
        if (CALIB_REQ) begin
          shift_nx  = '0;
          locked_nx = '0;
          done_nx   = 1'b0;
          fail_nx   = 1'b0;
          trial_nx  = '0;
          cnt_nx    = '0;
          busy_nx   = 1'b1;
        end else if (SHIFT_WE) begin
          shift_nx = SHIFT_I;
        end
      end
      S_SETTLE: begin
        if (settle_end) begin
          cnt_nx  = '0;
          pass_nx = '1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        // Already-locked lanes are not re-qualified; only unlocked lanes can drop out
        pass_nx = pass & (match | LOCKED);
        cnt_nx  = check_end ? '0 : cnt + CNT_W'(1);
      end
      S_ADVANCE: begin
        locked_nx = lock_acc;
        if (!adv_finish) begin
          trial_nx = trial + 3'd1;
          for (int l = 0; l < LANES; l++)
            if (!lock_acc[l]) shift_nx[3*l +: 3] = trial + 3'd1;
        end
      end
      S_FINISH: begin
        for (int l = 0; l < LANES; l++)
          if (!LOCKED[l]) shift_nx[3*l +: 3] = 3'd0;
        done_nx = &LOCKED;
        fail_nx = ~&LOCKED;
        busy_nx = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage 1: registered aligned outputs and control state
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      trial   <= '0;
      pass    <= '0;
      SHIFT_O <= '0;
      LOCKED  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      FAIL    <= 1'b0;
      PHASE   <= 1'b0;
      Q0      <= '0;
      Q1      <= '0;
      b_p1    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      trial   <= trial_nx;
      pass    <= pass_nx;
      SHIFT_O <= shift_nx;
      LOCKED  <= locked_nx;
      BUSY    <= busy_nx;
      DONE    <= done_nx;
      FAIL    <= fail_nx;
      PHASE   <= ~PHASE;
      Q0      <= (slip_p0 & b_p1) | (~slip_p0 & a_p0);
      Q1      <= (slip_p0 & a_p0) | (~slip_p0 & b_p0);
      b_p1    <= b_p0;
    end
  end
endmodule

// File: tb/tb_gw2a_ddr_rdalign.sv
// Randomised bench for gw2a_ddr_rdalign (2 lanes) against a behavioural model
// that predicts lock results and calibration length from the stimulus tables.
module tb_gw2a_ddr_rdalign;
  localparam int         LN   = 2;
  localparam logic [3:0] PAT  = 4'b1001;
  localparam int         TLEN = 4 + 8 + 1;

  logic          PCLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CALIB_REQ = 1'b0;
  logic          SHIFT_WE = 1'b0;
  logic [3*LN-1:0] SHIFT_I = '0;
  logic [4*LN-1:0] DI = '0;
  logic [LN-1:0] Q0, Q1, LOCKED;
  logic [3*LN-1:0] SHIFT_O;
  logic          PHASE, BUSY, DONE, FAIL;

  gw2a_ddr_rdalign #(.LANES(LN), .PATTERN(PAT), .SETTLE(4), .CHECKS(8)) dut (
    .PCLK(PCLK), .RESET_N(RESET_N), .CALIB_REQ(CALIB_REQ), .SHIFT_WE(SHIFT_WE),
    .SHIFT_I(SHIFT_I), .DI(DI), .Q0(Q0), .Q1(Q1), .SHIFT_O(SHIFT_O),
    .LOCKED(LOCKED), .PHASE(PHASE), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus tables: nib[lane][phase] is the nibble launched while PHASE==phase
  logic [3:0] nib [LN][2];
  int mode = 0;

  function automatic logic [1:0] pat_half(input logic p);
    return p ? PAT[3:2] : PAT[1:0];
  endfunction

  // Steady-state {Q1,Q0} for select s when nibble d follows nibble dp
  function automatic logic [1:0] out_of(input logic [2:0] s, input logic [3:0] d, input logic [3:0] dp);
    logic [1:0] ka, kb;
    ka = s[1:0];
    kb = ka + 2'd2;
    if (s[2]) return {d[ka], dp[kb]};
    return {d[kb], d[ka]};
  endfunction

  function automatic int lane_lock(input int l);
    for (int s = 0; s < 8; s++)
      if (out_of(3'(s), nib[l][0], nib[l][1]) == pat_half(1'b1) &&
          out_of(3'(s), nib[l][1], nib[l][0]) == pat_half(1'b0))
        return s;
    return 8;
  endfunction

  function automatic int plan_final();
    int mx;
    mx = 0;
    for (int l = 0; l < LN; l++) begin
      if (lane_lock(l) == 8) return 7;
      if (lane_lock(l) > mx) mx = lane_lock(l);
    end
    return mx;
  endfunction

  task automatic build(input int l, input logic [2:0] s);
    logic [1:0] ka, kb;
    logic [1:0] want;
    ka = s[1:0];
    kb = ka + 2'd2;
    for (int p = 0; p < 2; p++) begin
      nib[l][p] = 4'($urandom);
      want = pat_half(~1'(p));
      if (!s[2]) begin
        nib[l][p][ka] = want[0];
        nib[l][p][kb] = want[1];
      end else begin
        nib[l][p][ka] = want[1];
        nib[l][p][kb] = pat_half(1'(p)) & 2'b01 ? 1'b1 : 1'b0;
      end
    end
  endtask

  // Behavioural model state (value after each edge)
  logic [LN-1:0] m_q0 = '0, m_q1 = '0, m_bprev = '0, m_locked = '0;
  logic [2:0]    m_sel [LN];
  logic          m_phase = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_fail = 1'b0;
  int            m_k = 0, m_T = 0, m_nfinal = 0;
  int            m_lock [LN];

  function automatic logic [3*LN-1:0] m_shift();
    logic [3*LN-1:0] v;
    for (int l = 0; l < LN; l++) v[3*l +: 3] = m_sel[l];
    return v;
  endfunction

  always @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_q0 = '0; m_q1 = '0; m_bprev = '0; m_locked = '0;
      m_phase = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_fail = 1'b0;
      for (int l = 0; l < LN; l++) m_sel[l] = 3'd0;
    end else begin
      for (int l = 0; l < LN; l++) begin
        logic [3:0] d;
        logic [1:0] ka, kb;
        d  = DI[4*l +: 4];
        ka = m_sel[l][1:0];
        kb = ka + 2'd2;
        m_q0[l]    = m_sel[l][2] ? m_bprev[l] : d[ka];
        m_q1[l]    = m_sel[l][2] ? d[ka] : d[kb];
        m_bprev[l] = d[kb];
      end
      m_phase = ~m_phase;
      if (!m_busy) begin
        if (CALIB_REQ) begin
          m_busy = 1'b1; m_done = 1'b0; m_fail = 1'b0; m_locked = '0; m_k = 0;
          for (int l = 0; l < LN; l++) begin
            m_sel[l]  = 3'd0;
            m_lock[l] = lane_lock(l);
          end
          m_nfinal = plan_final();
          m_T = (m_nfinal + 1) * TLEN + 1;
        end else if (SHIFT_WE) begin
          for (int l = 0; l < LN; l++) m_sel[l] = SHIFT_I[3*l +: 3];
        end
      end else begin
        m_k++;
        for (int l = 0; l < LN; l++) begin
          int v;
          m_locked[l] = (m_lock[l] < 8) && (m_k >= TLEN * (m_lock[l] + 1));
          v = m_k / TLEN;
          if (v > m_lock[l]) v = m_lock[l];
          if (v > m_nfinal) v = m_nfinal;
          m_sel[l] = 3'(v);
          if (m_k == m_T) m_sel[l] = (m_lock[l] < 8) ? 3'(m_lock[l]) : 3'd0;
        end
        if (m_k == m_T) begin
          m_busy = 1'b0;
          m_done = &m_locked;
          m_fail = ~&m_locked;
        end
      end
    end
  end

  always @(posedge PCLK) begin
    #1;
    chk("q0", Q0, m_q0);
    chk("q1", Q1, m_q1);
    chk("shift_o", SHIFT_O, m_shift());
    chk("locked", LOCKED, m_locked);
    chk("phase", PHASE, m_phase);
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_done);
    chk("fail", FAIL, m_fail);
  end

  always @(negedge PCLK) begin
    case (mode)
      1: for (int l = 0; l < LN; l++) DI[4*l +: 4] = nib[l][m_phase];
      2: DI = {4'($urandom), 4'b1000};
      default: DI = 8'($urandom);
    endcase
  end

  task automatic run_cal(input int req_at, input int we_at, input bit we_with_req,
                         input int rst_at, output int n);
    CALIB_REQ = 1'b1;
    if (we_with_req) begin
      SHIFT_WE = 1'b1;
      SHIFT_I  = 6'b111111;
    end
    @(negedge PCLK);
    CALIB_REQ = 1'b0;
    SHIFT_WE  = 1'b0;
    n = 0;
    while (BUSY === 1'b1 && n < 300) begin
      n++;
      if (n == rst_at) begin
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_locked", LOCKED, 0);
        chk("rst_mid_shift", SHIFT_O, 0);
        return;
      end
      CALIB_REQ = (n == req_at);
      SHIFT_WE  = (n == we_at);
      SHIFT_I   = 6'($urandom);
      @(negedge PCLK);
    end
    CALIB_REQ = 1'b0;
    SHIFT_WE  = 1'b0;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL cal_timeout: BUSY still high after %0d cycles", n);
    end
  endtask

  task automatic set_success();
    nib[0][0] = 4'b1001; nib[0][1] = 4'b0110;
    nib[1][0] = 4'b1010; nib[1][1] = 4'b0000;
  endtask

  initial begin
    int n;
    mode = 0;
    repeat (4) @(negedge PCLK);
    chk("rst_q", {Q1, Q0}, 0);
    chk("rst_ctl", {PHASE, BUSY, DONE, FAIL}, 0);
    RESET_N = 1'b1;
    @(negedge PCLK);
    chk("phase_first", PHASE, 1);
    @(negedge PCLK);
    chk("phase_second", PHASE, 0);
    repeat (4) @(negedge PCLK);

    // Manual select: lane0 s=3 on 1000 gives Q0=1,Q1=0; lane1 s=4 slips
    mode = 2;
    @(negedge PCLK);
    SHIFT_I = {3'b100, 3'b011};
    SHIFT_WE = 1'b1;
    @(negedge PCLK);
    SHIFT_WE = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("man_shift", SHIFT_O, 6'b100011);
    chk("man_lane0", {Q1[0], Q0[0]}, 2'b01);
    repeat (4) @(negedge PCLK);

    // Calibration success
    set_success();
    mode = 1;
    chk("model_lock0", lane_lock(0), 1);
    chk("model_lock1", lane_lock(1), 5);
    repeat (3) @(negedge PCLK);
    run_cal(-1, -1, 1'b0, -1, n);
    chk("ok_busy_len", n, 79);
    chk("ok_shift", SHIFT_O, 6'b101001);
    chk("ok_locked", LOCKED, 2'b11);
    chk("ok_done_fail", {DONE, FAIL}, 2'b10);
    repeat (3) @(negedge PCLK);

    // Calibration failure: lane1 dead
    nib[1][0] = 4'b0000; nib[1][1] = 4'b0000;
    chk("model_lock1_dead", lane_lock(1), 8);
    repeat (3) @(negedge PCLK);
    run_cal(-1, -1, 1'b0, -1, n);
    chk("bad_busy_len", n, 105);
    chk("bad_shift", SHIFT_O, 6'b000001);
    chk("bad_locked", LOCKED, 2'b01);
    chk("bad_done_fail", {DONE, FAIL}, 2'b01);
    repeat (3) @(negedge PCLK);

    // Requests and manual writes while busy are ignored
    set_success();
    repeat (3) @(negedge PCLK);
    run_cal(20, 40, 1'b0, -1, n);
    chk("busy_req_len", n, 79);
    chk("busy_req_shift", SHIFT_O, 6'b101001);
    repeat (3) @(negedge PCLK);

    // SHIFT_WE with CALIB_REQ: calibration wins
    run_cal(-1, -1, 1'b1, -1, n);
    chk("contend_len", n, 79);
    chk("contend_shift", SHIFT_O, 6'b101001);
    repeat (3) @(negedge PCLK);

    // Reset during CHECK of trial 3, then recalibrate from scratch
    nib[1][0] = 4'b0000; nib[1][1] = 4'b0000;
    repeat (3) @(negedge PCLK);
    run_cal(-1, -1, 1'b0, 45, n);
    repeat (2) @(negedge PCLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge PCLK);
    run_cal(-1, -1, 1'b0, -1, n);
    chk("recal_len", n, 105);
    chk("recal_locked", LOCKED, 2'b01);
    chk("recal_fail", FAIL, 1);
    repeat (3) @(negedge PCLK);

    // Randomised scenarios
    for (int it = 0; it < 8; it++) begin
      int exp_t;
      mode = 0;
      SHIFT_I = 6'($urandom);
      SHIFT_WE = 1'b1;
      @(negedge PCLK);
      SHIFT_WE = 1'b0;
      repeat (3) @(negedge PCLK);
      for (int l = 0; l < LN; l++) begin
        int r;
        r = $urandom_range(0, 3);
        nib[l][0] = 4'($urandom);
        nib[l][1] = 4'($urandom);
        if (r == 1 || r == 2) build(l, 3'($urandom_range(0, 7)));
        else if (r == 3) begin
          nib[l][0] = 4'b0000;
          nib[l][1] = 4'b0000;
        end
      end
      mode = 1;
      repeat (2) @(negedge PCLK);
      exp_t = (plan_final() + 1) * TLEN + 1;
      run_cal($urandom_range(1, 60), $urandom_range(1, 60), 1'($urandom_range(0, 1)), -1, n);
      chk("rnd_busy_len", n, exp_t);
      repeat (2) @(negedge PCLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
